// File: rtl/conv_sched.sv
// Arbitrates two requesters onto one convolution engine: loads filter and image bytes,
// streams them to the engine and routes the engine results back to the owning requester.
module conv_sched #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [1:0]  req_fsize,
  input  logic [7:0]  req_isize,
  input  logic [1:0]  req_pad,
  input  logic [1:0]  req_act,
  input  logic [1:0]  in_valid,
  input  logic [15:0] in_data,
  output logic [1:0]  in_ready,
  output logic [1:0]  gnt,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic        busy,
  output logic        conv_filter_valid,
  output logic        conv_image_valid,
  output logic        conv_filter_size,
  output logic        conv_pad_mode,
  output logic        conv_act_mode,
  output logic [3:0]  conv_image_size,
  output logic [7:0]  conv_in_data,
  input  logic        conv_out_valid,
  input  logic [15:0] conv_out_data,
  output logic        res_valid,
  output logic        res_id,
  output logic [15:0] res_data
);

  localparam int unsigned CW     = 7;
  localparam int unsigned TW     = 10;
  localparam int unsigned FDEPTH = 25;
  localparam int unsigned IDEPTH = 64;

  typedef enum logic [2:0] {IDLE, GRANT, LOAD, FILT, GAP, IMG, WAIT, DONE} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [TW-1:0]   tmo, tmo_n;
  logic            sel, sel_n, last, last_n;
  logic            fsz_n, pad_n, act_n;
  logic [3:0]      isz_n;
  logic [CW-1:0]   f_len, nn, total;
  logic [3:0]      sel_isize;
  logic [7:0]      sel_byte;
  logic            accept, wr_filt, wr_img;
  logic [1:0]      in_ready_n, gnt_n, done_n, err_n, sel_oh_n;
  logic            fv_n, iv_n, rv_n;
  logic [7:0]      data_n;

  logic [7:0] filt_mem [FDEPTH];
  logic [7:0] img_mem  [IDEPTH];

  assign f_len     = conv_filter_size ? CW'(25) : CW'(9);
  assign nn        = CW'(conv_image_size) * CW'(conv_image_size);
  assign total     = f_len + nn;
  assign sel_isize = sel ? req_isize[7:4] : req_isize[3:0];
  assign sel_byte  = sel ? in_data[15:8] : in_data[7:0];
  assign accept    = in_valid[sel] & in_ready[sel];

  // Next state, counters and the next value of every registered output
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    tmo_n   = tmo;
    sel_n   = sel;
    last_n  = last;
    fsz_n   = conv_filter_size;
    isz_n   = conv_image_size;
    pad_n   = conv_pad_mode;
    act_n   = conv_act_mode;
    err_n   = 2'b00;
    wr_filt = 1'b0;
    wr_img  = 1'b0;

    case (state)
      IDLE: begin
        if (|req) begin
          state_n = GRANT;
          sel_n   = (&req) ? ~last : req[1];
        end
      end
      GRANT: begin
        fsz_n = req_fsize[sel];
        isz_n = sel_isize;
        pad_n = req_pad[sel];
        act_n = req_act[sel];
        cnt_n = '0;
        if (sel_isize < 4'd4 || sel_isize > 4'd8) begin
          err_n[sel] = 1'b1;
          last_n     = sel;
          state_n    = IDLE;
        end else begin
          state_n = LOAD;
        end
      end
      LOAD: begin
        if (accept) begin
          cnt_n = cnt + CW'(1);
          if (cnt < f_len) wr_filt = 1'b1;
          else             wr_img  = 1'b1;
          if (cnt == total - CW'(1)) begin
            state_n = FILT;
            cnt_n   = '0;
          end
        end
      end
      FILT: begin
        cnt_n = cnt + CW'(1);
        if (cnt == f_len - CW'(1)) begin
          state_n = GAP;
          cnt_n   = '0;
        end
      end
      GAP: begin
        state_n = IMG;
        cnt_n   = '0;
      end
      IMG: begin
        cnt_n = cnt + CW'(1);
        if (cnt == nn - CW'(1)) begin
          state_n = WAIT;
          cnt_n   = '0;
          tmo_n   = '0;
        end
      end
      WAIT: begin
        if (conv_out_valid) begin
          tmo_n = '0;
          cnt_n = cnt + CW'(1);
          if (cnt == nn - CW'(1)) state_n = DONE;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          err_n[sel] = 1'b1;
          last_n     = sel;
          state_n    = IDLE;
        end else begin
          tmo_n = tmo + TW'(1);
        end
      end
      DONE: begin
        last_n  = sel;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    sel_oh_n   = {sel_n, ~sel_n};
    in_ready_n = (state_n == LOAD) ? sel_oh_n : 2'b00;
    gnt_n      = (state_n != IDLE) ? sel_oh_n : 2'b00;
    done_n     = (state_n == DONE) ? sel_oh_n : 2'b00;
    fv_n       = (state_n == FILT);
    iv_n       = (state_n == IMG);
    data_n     = fv_n ? filt_mem[cnt_n[4:0]] : (iv_n ? img_mem[cnt_n[5:0]] : 8'h00);
    rv_n       = (state == WAIT) && conv_out_valid;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      cnt               <= '0;
      tmo               <= '0;
      sel               <= 1'b0;
      last              <= 1'b1;
      in_ready          <= '0;
      gnt               <= '0;
      done              <= '0;
      err               <= '0;
      busy              <= 1'b0;
      conv_filter_valid <= 1'b0;
      conv_image_valid  <= 1'b0;
      conv_filter_size  <= 1'b0;
      conv_pad_mode     <= 1'b0;
      conv_act_mode     <= 1'b0;
      conv_image_size   <= '0;
      conv_in_data      <= '0;
      res_valid         <= 1'b0;
      res_id            <= 1'b0;
      res_data          <= '0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      tmo               <= tmo_n;
      sel               <= sel_n;
      last              <= last_n;
      in_ready          <= in_ready_n;
      gnt               <= gnt_n;
      done              <= done_n;
      err               <= err_n;
      busy              <= (state_n != IDLE);
      conv_filter_valid <= fv_n;
      conv_image_valid  <= iv_n;
      conv_filter_size  <= fsz_n;
      conv_pad_mode     <= pad_n;
      conv_act_mode     <= act_n;
      conv_image_size   <= isz_n;
      conv_in_data      <= data_n;
      res_valid         <= rv_n;
      if (rv_n) begin
        res_id   <= sel;
        res_data <= conv_out_data;
      end
    end
  end

  // Byte buffers hold no state across jobs, so they carry no reset
  always_ff @(posedge clk) begin
    if (wr_filt) filt_mem[cnt[4:0]] <= sel_byte;
    if (wr_img)  img_mem[6'(cnt - f_len)] <= sel_byte;
  end

endmodule

// File: tb/tb_conv_sched.sv
// Directed bench for conv_sched: acts as both requesters and the convolution engine,
// checking byte streams, strobe timing, arbitration, rejects, timeout and reset abort.
module tb_conv_sched;

  localparam int unsigned TMO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req, req_fsize, req_pad, req_act, in_valid;
  logic [7:0]  req_isize;
  logic [15:0] in_data;
  logic [1:0]  in_ready, gnt, done, err;
  logic        busy, conv_filter_valid, conv_image_valid, conv_filter_size;
  logic        conv_pad_mode, conv_act_mode;
  logic [3:0]  conv_image_size;
  logic [7:0]  conv_in_data;
  logic        conv_out_valid;
  logic [15:0] conv_out_data;
  logic        res_valid, res_id;
  logic [15:0] res_data;

  int n_checks = 0;
  int n_errors = 0;

  conv_sched #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_fsize(req_fsize), .req_isize(req_isize),
    .req_pad(req_pad), .req_act(req_act), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .gnt(gnt), .done(done), .err(err), .busy(busy),
    .conv_filter_valid(conv_filter_valid), .conv_image_valid(conv_image_valid),
    .conv_filter_size(conv_filter_size), .conv_pad_mode(conv_pad_mode),
    .conv_act_mode(conv_act_mode), .conv_image_size(conv_image_size),
    .conv_in_data(conv_in_data), .conv_out_valid(conv_out_valid),
    .conv_out_data(conv_out_data), .res_valid(res_valid), .res_id(res_id),
    .res_data(res_data)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] bval(input int r, input int i);
    return 8'(i * 13 + r * 5 + 3);
  endfunction

  function automatic logic [15:0] rval(input int r, input int k);
    return 16'(k * 771 + r * 17 + 4660);
  endfunction

  function automatic logic [63:0] all_outs();
    return 64'({busy, gnt, in_ready, done, err, conv_filter_valid, conv_image_valid,
                conv_filter_size, conv_pad_mode, conv_act_mode, conv_image_size,
                conv_in_data, res_valid, res_id, res_data});
  endfunction

  task automatic set_req(input int r, input bit fs, input int n);
    req_fsize[r]       = fs;
    req_isize[r*4 +: 4] = 4'(n);
    req_pad[r]         = n[0];
    req_act[r]         = fs ^ r[0];
    req[r]             = 1'b1;
  endtask

  // One job for requester r; stall >= 0 makes the engine stop after that many results,
  // rst_img asserts reset during the image phase and returns with rst_n held low.
  task automatic run_job(input int r, input bit fs, input int n, input bit tog,
                         input int stall, input bit rst_img);
    int f, nn, total, acc, fi, ii, ff, lf, fimg, limg, sent, got, dn, er, cyc;
    int last_drv, err_cyc, target;
    bit eng, fin;
    logic [15:0] q[$];
    logic [15:0] d;
    logic [1:0]  oh;
    f = fs ? 25 : 9;
    nn = n * n;
    total = f + nn;
    oh = (r == 0) ? 2'b01 : 2'b10;
    target = (stall >= 0) ? stall : nn;
    acc = 0; fi = 0; ii = 0; ff = 0; lf = 0; fimg = 0; limg = 0;
    sent = 0; got = 0; dn = 0; er = 0; last_drv = 0; err_cyc = 0;
    eng = 1'b0; fin = 1'b0;
    set_req(r, fs, n);
    cyc = 0;
    while (gnt == 2'b00 && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    check("gnt_sel", 64'(gnt), 64'(oh));
    cyc = 0;
    while (!fin && cyc < 3000) begin
      if (res_valid) begin
        if (q.size() == 0) check("res_spurious", 64'(1), 64'(0));
        else begin
          d = q.pop_front();
          check("res_data", 64'(res_data), 64'(d));
          check("res_id", 64'(res_id), 64'(r));
          got++;
        end
      end
      if (conv_filter_valid) begin
        if (fi == 0) begin
          ff = cyc;
          check("cfg", 64'({conv_filter_size, conv_image_size, conv_pad_mode, conv_act_mode}),
                64'({fs, 4'(n), n[0], fs ^ r[0]}));
        end
        check("filt_byte", 64'(conv_in_data), 64'(bval(r, fi)));
        fi++;
        lf = cyc;
      end else if (conv_image_valid) begin
        if (ii == 0) fimg = cyc;
        check("img_byte", 64'(conv_in_data), 64'(bval(r, f + ii)));
        ii++;
        limg = cyc;
      end else begin
        check("data_idle", 64'(conv_in_data), 64'(0));
      end
      if (done[r]) dn++;
      if (err[r]) begin
        er++;
        err_cyc = cyc;
      end
      if (in_ready != 2'b00) check("ready_mask", 64'(in_ready), 64'(oh));
      if (rst_img && ii == 3) begin
        rst_n = 1'b0;
        req[r] = 1'b0;
        #1;
        check("rst_outs", all_outs(), 64'(0));
        return;
      end
      conv_out_valid = 1'b0;
      in_valid = 2'b00;
      if (acc < total && (!tog || (cyc % 2) == 1)) begin
        in_valid[r] = 1'b1;
        in_data[r*8 +: 8] = bval(r, acc);
        if (in_ready[r]) acc++;
      end
      if (conv_filter_valid && fi == 3) begin
        conv_out_valid = 1'b1;
        conv_out_data  = 16'hdead;
      end else if (eng && sent < target && (cyc % 4) != 3) begin
        conv_out_valid = 1'b1;
        conv_out_data  = rval(r, sent);
        q.push_back(rval(r, sent));
        sent++;
        last_drv = cyc;
      end
      if (conv_image_valid && ii == nn) eng = 1'b1;
      if (dn > 0 || er > 0) begin
        fin = 1'b1;
        req[r] = 1'b0;
        in_valid = 2'b00;
        conv_out_valid = 1'b0;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    if (!fin) check("job_end", 64'(0), 64'(1));
    check("loaded", 64'(acc), 64'(total));
    check("filt_cnt", 64'(fi), 64'(f));
    check("filt_contig", 64'(lf - ff + 1), 64'(f));
    check("gap", 64'(fimg - lf), 64'(2));
    check("img_cnt", 64'(ii), 64'(nn));
    check("img_contig", 64'(limg - fimg + 1), 64'(nn));
    check("res_cnt", 64'(got), 64'(target));
    if (stall < 0) begin
      check("done_cnt", 64'(dn), 64'(1));
      check("err_cnt", 64'(er), 64'(0));
    end else begin
      check("done_cnt", 64'(dn), 64'(0));
      check("err_cnt", 64'(er), 64'(1));
      check("tmo_cycles", 64'(err_cyc - last_drv), 64'(TMO + 1));
    end
    @(posedge clk); #1;
    check("pulse_width", 64'({done[r], err[r]}), 64'(0));
  endtask

  initial begin
    rst_n = 1'b0;
    req = '0; req_fsize = '0; req_isize = '0; req_pad = '0; req_act = '0;
    in_valid = '0; in_data = '0; conv_out_valid = 1'b0; conv_out_data = '0;
    #2;
    check("reset_outs", all_outs(), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_job(0, 1'b0, 4, 1'b0, -1, 1'b0);
    run_job(1, 1'b1, 8, 1'b1, -1, 1'b0);

    // simultaneous requests alternate
    set_req(1, 1'b0, 5);
    run_job(0, 1'b0, 4, 1'b0, -1, 1'b0);
    run_job(1, 1'b0, 5, 1'b0, -1, 1'b0);
    set_req(1, 1'b0, 4);
    run_job(0, 1'b1, 5, 1'b0, -1, 1'b0);
    run_job(1, 1'b0, 4, 1'b0, -1, 1'b0);

    // invalid image size on r0 while r1 waits
    begin
      bit seen;
      seen = 1'b0;
      set_req(0, 1'b0, 3);
      set_req(1, 1'b0, 5);
      for (int i = 0; i < 20 && !seen; i++) begin
        @(posedge clk); #1;
        check("rej_quiet", 64'({in_ready, conv_filter_valid, conv_image_valid}), 64'(0));
        if (err[0]) begin
          seen = 1'b1;
          req[0] = 1'b0;
        end
      end
      check("rej_err", 64'(seen), 64'(1));
      @(posedge clk); #1;
      check("rej_pulse", 64'(err), 64'(0));
      run_job(1, 1'b0, 5, 1'b0, -1, 1'b0);
    end

    run_job(0, 1'b0, 4, 1'b0, 5, 1'b0);

    // reset during image streaming, then power-up arbitration again
    run_job(1, 1'b0, 4, 1'b0, -1, 1'b1);
    repeat (2) begin
      @(posedge clk); #1;
      check("rst_hold", 64'({done, err, busy}), 64'(0));
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_req(1, 1'b1, 6);
    run_job(0, 1'b0, 4, 1'b0, -1, 1'b0);
    run_job(1, 1'b1, 6, 1'b0, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
